// File: rtl/gpio_z_pkg.sv
// Shared definitions for the gpio_z inter-board link: line bit positions,
// symbol width and receiver FSM states. Also used by the FPGA1 sender.
package gpio_z_pkg;

  localparam int unsigned LINE_W     = 4;
  localparam int unsigned STROBE_BIT = 3;
  localparam int unsigned SOF_BIT    = 2;
  localparam int unsigned DATA_MSB   = 1;
  localparam int unsigned DATA_LSB   = 0;
  localparam int unsigned SYM_W      = 2;

  typedef enum logic [0:0] {
    StIdle,
    StCollect
  } rx_state_e;

endpackage

// File: rtl/gpio_z_sync.sv
// Multi-stage, multi-bit synchroniser for asynchronous input lines.
// All stages reset to zero.
module gpio_z_sync #(
  parameter int unsigned Stages = 2,
  parameter int unsigned Width  = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Stages-1:0][Width-1:0] sync_q;

  // Shift raw lines through the synchroniser chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/gpio_z_rx.sv
// Receiver for the gpio_z link: synchronises the pins, detects STROBE toggles,
// assembles 2-bit symbols into words and presents them on a valid/ready port
// with sticky overrun / framing-error / done status.
module gpio_z_rx
  import gpio_z_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned SYM_PER_WORD = 4,
  parameter int unsigned TIMEOUT_CYC  = 1024,
  localparam int unsigned WORD_W      = SYM_W * SYM_PER_WORD
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [3:0]        gpio_z_in,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic              clear_err,
  output logic              rx_overrun,
  output logic              rx_frame_err,
  output logic              rx_done
);

  localparam int unsigned PrimeCyc = SYNC_STAGES + 1;
  localparam int unsigned PrimeW   = $clog2(PrimeCyc + 1);
  localparam int unsigned CntW     = $clog2(SYM_PER_WORD + 1);
  localparam int unsigned TmrW     = $clog2(TIMEOUT_CYC);

  logic [LINE_W-1:0] gpio_sync;
  logic              sync_strobe;
  logic              sof_s;
  logic [SYM_W-1:0]  data_s;

  logic [PrimeW-1:0] prime_q;
  logic              primed;
  logic              prev_strobe_q;
  logic              sym_evt;

  rx_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_nxt;
  logic [WORD_W-1:0] shift_q, shift_nxt;
  logic [TmrW-1:0]   tmr_q;

  logic              take;
  logic              restart;
  logic              frame_evt;
  logic              timeout;
  logic              word_done;
  logic              slot_free;

  logic [WORD_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              rx_overrun_q;
  logic              rx_frame_err_q;
  logic              rx_done_q;

  gpio_z_sync #(
    .Stages(SYNC_STAGES),
    .Width (LINE_W)
  ) u_sync (
    .clk_i (clk_clk),
    .rst_ni(reset_reset_n),
    .d_i   (gpio_z_in),
    .q_o   (gpio_sync)
  );

  assign sync_strobe = gpio_sync[STROBE_BIT];
  assign sof_s       = gpio_sync[SOF_BIT];
  assign data_s      = gpio_sync[DATA_MSB:DATA_LSB];

  // Mask edge detection until the synchroniser holds real pin values, so a
  // line already high at reset release is not seen as a toggle.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      prime_q       <= '0;
      prev_strobe_q <= 1'b0;
    end else begin
      if (!primed) prime_q <= prime_q + 1'b1;
      prev_strobe_q <= sync_strobe;
    end
  end

  assign primed  = (prime_q == PrimeW'(PrimeCyc));
  assign sym_evt = primed & (sync_strobe ^ prev_strobe_q);

  // FSM state register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM actions: which symbols are taken, restarts, errors and completion.
  always_comb begin
    take      = 1'b0;
    restart   = 1'b0;
    frame_evt = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sym_evt) begin
          if (sof_s) begin
            take    = 1'b1;
            restart = 1'b1;
          end else begin
            frame_evt = 1'b1;
          end
        end
      end
      StCollect: begin
        if (sym_evt) begin
          take = 1'b1;
          if (sof_s) begin
            // Unexpected SOF: drop the partial word and start over with this symbol.
            frame_evt = 1'b1;
            restart   = 1'b1;
          end
        end else if (tmr_q == TmrW'(TIMEOUT_CYC - 1)) begin
          frame_evt = 1'b1;
          timeout   = 1'b1;
        end
      end
      default: ;
    endcase
    cnt_nxt   = restart ? CntW'(1) : cnt_q + 1'b1;
    shift_nxt = WORD_W'({shift_q, data_s});
    word_done = take && (cnt_nxt == CntW'(SYM_PER_WORD));
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    if (word_done || timeout) begin
      state_d = StIdle;
    end else if (take) begin
      state_d = StCollect;
    end
  end

  // Symbol shift register, symbol counter and inactivity timer.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
      tmr_q   <= '0;
    end else begin
      if (take) begin
        shift_q <= shift_nxt;
        cnt_q   <= word_done ? '0 : cnt_nxt;
      end else if (timeout) begin
        cnt_q <= '0;
      end
      if (take || timeout || (state_q == StIdle)) begin
        tmr_q <= '0;
      end else begin
        tmr_q <= tmr_q + 1'b1;
      end
    end
  end

  assign slot_free = !rx_valid_q || rx_ready;

  // Output slot and sticky status flags; a new error event beats clear_err.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_overrun_q   <= 1'b0;
      rx_frame_err_q <= 1'b0;
      rx_done_q      <= 1'b0;
    end else begin
      if (word_done && slot_free) begin
        rx_data_q  <= shift_nxt;
        rx_valid_q <= 1'b1;
        rx_done_q  <= 1'b1;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      rx_overrun_q   <= (rx_overrun_q & ~clear_err) | (word_done & ~slot_free);
      rx_frame_err_q <= (rx_frame_err_q & ~clear_err) | frame_evt;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_overrun   = rx_overrun_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_done      = rx_done_q;

endmodule
